// File: rtl/uart_wrapper_pkg.sv
// Shared constants and types for the UART command wrapper.
package uart_wrapper_pkg;

  // Default clk cycles per UART bit (50 MHz / 19200 baud)
  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

  // Byte-pairing states: waiting for the high byte or for the low byte
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } wrap_state_e;

  // Response codes
  localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/uart_wrapper_uart.sv
// 8N1 UART: synchronized receiver with rx_rdy/rx_err strobes, and a transmitter
// with trmt/tx_done handshake. Receive and transmit run independently.
module uart
  import uart_wrapper_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_err,
  output logic       tx_done
);

  localparam int unsigned HALF3 = BAUD_DIV * 3 / 2;
  localparam int unsigned CW    = $clog2(HALF3 + 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_busy_q, rx_busy_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic          rx_err_q, rx_err_d;

  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_done_q, tx_done_d;

  // Two-flop synchronizer (preset high = idle line) plus a delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next state: start on falling edge, sample at bit centres, idle at stop centre
  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_rdy_d   = rx_rdy_q;
    rx_err_d   = 1'b0;
    if (clr_rx_rdy) rx_rdy_d = 1'b0;
    if (!rx_busy_q) begin
      if (rx_prev_q && !rx_sync_q) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = CW'(HALF3 - 1);
        rx_bit_d  = '0;
      end
    end else if (rx_cnt_q == '0) begin
      rx_cnt_d = CW'(BAUD_DIV - 1);
      if (rx_bit_q == 4'd8) begin
        rx_busy_d = 1'b0;
        if (rx_sync_q) rx_rdy_d = 1'b1;
        else           rx_err_d = 1'b1;
      end else begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 4'd1;
      end
    end else begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_busy_q  <= rx_busy_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Transmitter next state: load {stop, data, start} on trmt when idle, shift every bit period
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = tx_done_q;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_shift_d = {1'b1, tx_data, 1'b0};
        tx_busy_d  = 1'b1;
        tx_cnt_d   = CW'(BAUD_DIV - 1);
        tx_bit_d   = '0;
        tx_done_d  = 1'b0;
      end
    end else if (tx_cnt_q == '0) begin
      tx_cnt_d = CW'(BAUD_DIV - 1);
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign rx_data = rx_shift_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_err  = rx_err_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/uart_wrapper.sv
// Pairs received UART bytes into 16-bit commands and forwards responses to the transmitter.
module uart_wrapper
  import uart_wrapper_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  wrap_state_e state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic [7:0]  rx_data;
  logic        rx_rdy, rx_err, clr_rx_rdy;

  // rx_rdy is consumed the cycle it appears, so it acts as a one-cycle byte strobe
  assign clr_rx_rdy = rx_rdy;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .clr_rx_rdy(clr_rx_rdy),
    .tx_data   (resp),
    .trmt      (trmt),
    .TX        (TX),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .rx_err    (rx_err),
    .tx_done   (tx_done)
  );

  // Byte-pairing next state; a completed command's set of cmd_rdy wins over a coincident clear
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_d      = rx_data;
          cmd_rdy_d = 1'b0;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cmd_d     = {hi_q, rx_data};
          cmd_rdy_d = 1'b1;
          state_d   = WAIT_HI;
        end else if (rx_err) begin
          state_d = WAIT_HI;
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  // Pairing state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HI;
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 Parameter BAUD_DIV, default 2604, gives clk cycles per UART bit (50 MHz / 19200 baud).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 RX  input  1  serial data from remote (8N1, idle high); asynchronous to clk.
REQ-005 TX  output  1  serial response to remote (8N1, idle high).
REQ-006 cmd  output  16  assembled command, {first byte, second byte}.
REQ-007 cmd_rdy  output  1  level; a complete 16-bit command is valid on cmd.
REQ-008 clr_cmd_rdy  input  1  one-cycle pulse from the consumer acknowledging cmd.
REQ-009 resp  input  8  response byte to transmit.
REQ-010 trmt  input  1  one-cycle pulse; start transmitting resp.
REQ-011 tx_done  output  1  level; the last requested response byte is fully sent.

Function
REQ-012 RX shall pass through a two-flop synchronizer (preset high) before any use.
REQ-013 Receiver: a falling edge on synchronized RX while idle starts a frame; data bits sampled at bit centres (first sample BAUD_DIV*3/2 after the edge, then every BAUD_DIV), LSB first.
REQ-014 Receiver: the stop bit is sampled at its centre; stop = 0 is a framing error, and the byte is discarded without a byte-valid strobe.
REQ-015 Receiver shall be back in idle at the stop-bit centre sample, so a back-to-back start bit is not missed.
REQ-016 Wrapper FSM states: WAIT_HI and WAIT_LO.
REQ-017 WAIT_HI: a valid byte latches the high byte, clears cmd_rdy, and moves to WAIT_LO.
REQ-018 WAIT_LO: a valid byte drives cmd = {high, byte} and sets cmd_rdy on the next clk edge; the FSM returns to WAIT_HI.
REQ-019 A framing error in WAIT_LO shall return the FSM to WAIT_HI, leaving cmd and cmd_rdy unchanged.
REQ-020 cmd shall remain stable while cmd_rdy = 1, until a new high byte arrives.
REQ-021 clr_cmd_rdy clears cmd_rdy; if it coincides with the set of REQ-018, the set wins.
REQ-022 Transmitter: trmt while idle loads {1, resp, 0}, clears tx_done, and shifts LSB-first every BAUD_DIV cycles.
REQ-023 Transmitter: TX goes low (start bit) on the cycle after trmt; total frame = 10*BAUD_DIV cycles.
REQ-024 Transmitter: tx_done sets after the full stop-bit period and holds until the next accepted trmt.
REQ-025 trmt while transmitting shall be ignored; the in-flight byte is not corrupted.
REQ-026 Receive and transmit paths shall operate fully concurrently.
REQ-027 Baud counters shall be wide enough for BAUD_DIV*3/2 with no wrap.

Reset
REQ-028 On rst_n low, immediately: TX = 1, cmd = 16'h0000, cmd_rdy = 0, tx_done = 0, FSM = WAIT_HI, and both shifters idle.
REQ-029 A reset mid-frame shall abandon the partial byte or command; no cmd_rdy follows the release of reset.

Structure
REQ-030 The shared package shall hold BAUD_DIV_DEFAULT, the wrapper FSM enum, and response codes (POS_ACK = 8'hA5).
REQ-031 One sub-module, uart (8N1 RX + TX with rx_rdy/clr_rx_rdy and trmt/tx_done), shall be instantiated once; the byte-pairing FSM lives in uart_wrapper.

Verification
REQ-032 Send bytes 8'h4B then 8'hF4 via RemoteComm -> cmd = 16'h4BF4, cmd_rdy = 1 within 2 clks of the second stop-bit centre.
REQ-033 With cmd_rdy = 1, pulse clr_cmd_rdy -> cmd_rdy = 0 next cycle, cmd still 16'h4BF4; then send 16'h2002 back-to-back -> cmd = 16'h2002.
REQ-034 Pulse trmt with resp = 8'hA5 -> TX frame 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing; RemoteComm resp = 8'hA5; tx_done set after 10*BAUD_DIV cycles.
REQ-035 Second trmt (resp = 8'h00) issued 3*BAUD_DIV into an 8'hA5 frame -> remote receives only 8'hA5.
REQ-036 Byte 8'h4B, then a frame with stop bit forced 0, then 8'h4B, 8'hF4 -> only cmd = 16'h4BF4 is produced, with one cmd_rdy rise.
REQ-037 Assert rst_n low after the first byte of 16'h4BF4 -> TX = 1, cmd_rdy = 0; after release, a fresh 16'h3FF1 yields cmd = 16'h3FF1.
